// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared constants and request type for the writeback unit
package regfile_wb_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS = 32;
  localparam int WB_XLEN = 32;
  localparam logic [REG_IDX_W-1:0] X0 = 5'd0;
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_writeback_unit_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests, DEPTH a power of two
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  wb_req_t din,
  output logic full,
  output logic empty,
  output logic [AW:0] count,
  output wb_req_t head
);
  wb_req_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  // storage carries no reset; validity is defined by the pointers alone
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit: arbitrates ALU and buffered memory results onto the RF write port and tracks pending destinations
// Optional forwarding ports are enabled with REGFILE_WB_BYPASS_EN.
module regfile_writeback_unit
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = WB_XLEN
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_valid,
  input  logic [4:0] issue_rd,
  input  logic alu_valid,
  input  logic [4:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic mem_valid,
  output logic mem_ready,
  input  logic [4:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic rf_write_enable,
  output logic [4:0] rf_rd,
  output logic [XLEN-1:0] rf_rd_din,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
`ifdef REGFILE_WB_BYPASS_EN
  output logic rs1_fwd,
  output logic rs2_fwd,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic [XLEN-1:0] rs2_fwd_data,
`endif
  output logic rs1_busy,
  output logic rs2_busy,
  output logic hazard,
  output logic [$clog2(DEPTH):0] fifo_count
);
  wb_req_t head, mem_req;
  logic full, empty, pop;
  logic [NUM_REGS-1:0] pending, set_mask, clr_mask;
  assign mem_req = '{rd: mem_rd, data: mem_data};
  assign mem_ready = !full;
  assign pop = !alu_valid && !empty;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(mem_valid && mem_ready),
    .pop(pop),
    .din(mem_req),
    .full(full),
    .empty(empty),
    .count(fifo_count),
    .head(head)
  );
  // ALU has strict priority; x0 destinations are consumed without a write strobe
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rf_write_enable <= 1'b0;
      rf_rd <= '0;
      rf_rd_din <= '0;
    end else if (alu_valid) begin
      rf_write_enable <= alu_rd != X0;
      rf_rd <= alu_rd;
      rf_rd_din <= alu_data;
    end else if (!empty) begin
      rf_write_enable <= head.rd != X0;
      rf_rd <= head.rd;
      rf_rd_din <= head.data;
    end else
      rf_write_enable <= 1'b0;
  assign set_mask = (issue_valid && issue_rd != X0) ? NUM_REGS'(1) << issue_rd : '0;
  assign clr_mask = rf_write_enable ? NUM_REGS'(1) << rf_rd : '0;
  // scoreboard: clear on the edge the RF captures, a same-edge issue wins, x0 never pending
  always_ff @(posedge clk or negedge reset)
    if (!reset) pending <= '0;
    else pending <= ((pending & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
  // re-issuing to a destination still in flight (and not retiring now) is illegal
  always_ff @(posedge clk)
    if (reset && issue_valid && issue_rd != X0)
      assert (!pending[issue_rd] || clr_mask[issue_rd]);
`ifdef REGFILE_WB_BYPASS_EN
  assign rs1_fwd = rf_write_enable && rf_rd == rs1 && rs1 != X0;
  assign rs2_fwd = rf_write_enable && rf_rd == rs2 && rs2 != X0;
  assign rs1_fwd_data = rf_rd_din;
  assign rs2_fwd_data = rf_rd_din;
  assign rs1_busy = pending[rs1] && !rs1_fwd;
  assign rs2_busy = pending[rs2] && !rs2_fwd;
`else
  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];
`endif
  assign hazard = rs1_busy | rs2_busy;
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb_regfile_writeback_unit: directed table, corner sequences and randomized run against a queue-based model
module tb_regfile_writeback_unit;
  import regfile_wb_pkg::*;
  localparam int DEPTH = 4;
`ifdef REGFILE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic issue_valid = 1'b0;
  logic [4:0] issue_rd = '0;
  logic alu_valid = 1'b0;
  logic [4:0] alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic mem_valid = 1'b0;
  logic mem_ready;
  logic [4:0] mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic rf_write_enable;
  logic [4:0] rf_rd;
  logic [31:0] rf_rd_din;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic rs1_busy, rs2_busy, hazard;
  logic [2:0] fifo_count;
`ifdef REGFILE_WB_BYPASS_EN
  logic rs1_fwd, rs2_fwd;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif
  always #5 clk = ~clk;
  regfile_writeback_unit #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .alu_valid(alu_valid),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd(mem_rd),
    .mem_data(mem_data),
    .rf_write_enable(rf_write_enable),
    .rf_rd(rf_rd),
    .rf_rd_din(rf_rd_din),
    .rs1(rs1),
    .rs2(rs2),
`ifdef REGFILE_WB_BYPASS_EN
    .rs1_fwd(rs1_fwd),
    .rs2_fwd(rs2_fwd),
    .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_data(rs2_fwd_data),
`endif
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .hazard(hazard),
    .fifo_count(fifo_count)
  );
  // reference model: a queue of buffered results, the visible write port and a pending bit per register
  wb_req_t q[$];
  logic m_we;
  logic [4:0] m_rd;
  logic [31:0] m_din;
  logic [31:0] pend;
  int pass_n = 0;
  int total_n = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic model_reset();
    q.delete();
    m_we = 1'b0;
    m_rd = '0;
    m_din = '0;
    pend = '0;
  endtask
  function automatic logic m_fwd(input logic [4:0] rs);
    return BYP && m_we && m_rd == rs && rs != 5'd0;
  endfunction
  function automatic logic m_busy(input logic [4:0] rs);
    return pend[rs] && !m_fwd(rs);
  endfunction
  task automatic check_model();
    chk("rf_write_enable", 64'(rf_write_enable), 64'(m_we));
    chk("rf_rd", 64'(rf_rd), 64'(m_rd));
    chk("rf_rd_din", 64'(rf_rd_din), 64'(m_din));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("mem_ready", 64'(mem_ready), 64'(q.size() != DEPTH));
    chk("rs1_busy", 64'(rs1_busy), 64'(m_busy(rs1)));
    chk("rs2_busy", 64'(rs2_busy), 64'(m_busy(rs2)));
    chk("hazard", 64'(hazard), 64'(m_busy(rs1) | m_busy(rs2)));
`ifdef REGFILE_WB_BYPASS_EN
    chk("rs1_fwd", 64'(rs1_fwd), 64'(m_fwd(rs1)));
    chk("rs2_fwd", 64'(rs2_fwd), 64'(m_fwd(rs2)));
    if (m_fwd(rs1)) chk("rs1_fwd_data", 64'(rs1_fwd_data), 64'(m_din));
    if (m_fwd(rs2)) chk("rs2_fwd_data", 64'(rs2_fwd_data), 64'(m_din));
`endif
  endtask
  task automatic model_edge();
    logic acc;
    wb_req_t e;
    acc = mem_valid && q.size() < DEPTH;
    if (m_we) pend[m_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) pend[issue_rd] = 1'b1;
    if (alu_valid) begin
      m_we = alu_rd != 5'd0;
      m_rd = alu_rd;
      m_din = alu_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = e.rd != 5'd0;
      m_rd = e.rd;
      m_din = e.data;
    end else
      m_we = 1'b0;
    if (acc) q.push_back('{rd: mem_rd, data: mem_data});
  endtask
  // inputs are set at a falling edge; check, advance the model, wait for the next falling edge
  task automatic step();
    #1 check_model();
    model_edge();
    @(negedge clk);
  endtask
  task automatic idle();
    issue_valid = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask
  typedef struct {
    logic iv; logic [4:0] ird;
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic mv; logic [4:0] mrd; logic [31:0] mdat;
    logic [4:0] rs;
    logic we; logic [4:0] rd; logic [31:0] din; logic [2:0] cnt; logic busy;
  } vec_t;
  vec_t tbl[14];
  initial begin
    tbl[0]  = '{1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd7, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 1'b1};
    tbl[2]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd7, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 1'b1};
    tbl[3]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h1234, 5'd7, 1'b0, 5'd5, 32'hDEADBEEF, 3'd1, 1'b1};
    tbl[4]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd7, 1'b1, 5'd7, 32'h1234,     3'd0, !BYP};
    tbl[5]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd7, 1'b0, 5'd7, 32'h1234,     3'd0, 1'b0};
    tbl[6]  = '{1'b1, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFF, 5'd0, 1'b0, 5'd7, 32'h1234,     3'd1, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 1'b0, 5'd0, 32'hFFFF,     3'd0, 1'b0};
    tbl[8]  = '{1'b1, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd9, 1'b0, 5'd0, 32'hFFFF,     3'd0, 1'b1};
    tbl[9]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,   5'd9, 1'b0, 5'd0, 32'hFFFF,     3'd1, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd9, 1'b1, 5'd9, 32'h99,       3'd0, !BYP};
    tbl[11] = '{1'b1, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd9, 1'b0, 5'd9, 32'h99,       3'd0, 1'b1};
    tbl[12] = '{1'b0, 5'd0, 1'b1, 5'd9, 32'h5,        1'b0, 5'd0, 32'h0,    5'd9, 1'b1, 5'd9, 32'h5,        3'd0, !BYP};
    tbl[13] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd9, 1'b0, 5'd9, 32'h5,        3'd0, 1'b0};
    model_reset();
    @(negedge clk);
    #1 check_model();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].mdat;
      rs1 = tbl[i].rs; rs2 = 5'd0;
      step();
      chk($sformatf("tbl%0d_we", i), 64'(rf_write_enable), 64'(tbl[i].we));
      chk($sformatf("tbl%0d_rd", i), 64'(rf_rd), 64'(tbl[i].rd));
      chk($sformatf("tbl%0d_din", i), 64'(rf_rd_din), 64'(tbl[i].din));
      chk($sformatf("tbl%0d_cnt", i), 64'(fifo_count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i), 64'(rs1_busy), 64'(tbl[i].busy));
    end
    idle();
    // fill the FIFO while the ALU holds the port, then drain in order
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'(i);
      mem_valid = 1'b1; mem_rd = 5'(10 + i); mem_data = 32'hA0 + 32'(i);
      step();
    end
    chk("fill_count", 64'(fifo_count), 64'd4);
    chk("fill_mem_ready", 64'(mem_ready), 64'd0);
    mem_valid = 1'b0;
    step();
    chk("full_hold_count", 64'(fifo_count), 64'd4);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain%0d_we", i), 64'(rf_write_enable), 64'd1);
      chk($sformatf("drain%0d_rd", i), 64'(rf_rd), 64'(10 + i));
      chk($sformatf("drain%0d_din", i), 64'(rf_rd_din), 64'(32'hA0 + 32'(i)));
    end
    step();
    chk("drained_we", 64'(rf_write_enable), 64'd0);
    chk("drained_count", 64'(fifo_count), 64'd0);
    // reset mid-traffic with 3 buffered entries and a pending register
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h77;
      mem_valid = 1'b1; mem_rd = 5'(20 + i); mem_data = 32'(i);
      step();
    end
    idle();
    rs1 = 5'd3; rs2 = 5'd3;
    #1 chk("pre_reset_count", 64'(fifo_count), 64'd3);
    chk("pre_reset_busy", 64'(rs1_busy), 64'd1);
    #1 reset = 1'b0;
    #1 chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    chk("rst_we", 64'(rf_write_enable), 64'd0);
    chk("rst_rs1_busy", 64'(rs1_busy), 64'd0);
    chk("rst_rs2_busy", 64'(rs2_busy), 64'd0);
    chk("rst_hazard", 64'(hazard), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // randomized traffic; light ALU load first, then heavy load to fill the FIFO
    for (int c = 0; c < 600; c++) begin
      alu_valid = $urandom_range(0, 99) < (c < 300 ? 30 : 75);
      alu_rd = 5'($urandom);
      alu_data = $urandom;
      if (!(mem_valid && !mem_ready)) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_rd = 5'($urandom);
        mem_data = $urandom;
      end
      issue_rd = 5'($urandom);
      issue_valid = $urandom_range(0, 2) == 0 && !pend[issue_rd];
      rs1 = 5'($urandom);
      rs2 = $urandom_range(0, 1) ? m_rd : 5'($urandom);
      step();
    end
    idle();
    for (int c = 0; c < 6; c++) step();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
